fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 126 ++++++++++++
 tb/tb_fetch_unit.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch front end: program counter, single-outstanding fetch FSM,
// instruction register with decoded fields, and a condition-flag status register.
module fetch_unit #(
    parameter int PC_W = 16,
    parameter int IR_W = 32
) (
    input  logic            clk,
    input  logic            rst_f,
    input  logic            pc_rst,
    input  logic            pc_write,
    input  logic            pc_sel,
    input  logic            br_sel,
    input  logic            ir_load,
    input  logic [3:0]      stat_in,
    input  logic            stat_en,
    output logic [PC_W-1:0] imem_addr,
    output logic            imem_req,
    input  logic [IR_W-1:0] imem_rdata,
    input  logic            imem_ready,
    output logic [PC_W-1:0] pc_out,
    output logic [IR_W-1:0] ir,
    output logic [3:0]      opcode,
    output logic [3:0]      mm,
    output logic [15:0]     imm,
    output logic [3:0]      stat,
    output logic            busy,
    output logic            fetch_err
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t            state_reg, state_next;
    logic [PC_W-1:0]   pc_reg, pc_next;
    logic [PC_W-1:0]   addr_reg, addr_next;
    logic [IR_W-1:0]   ir_reg, ir_next;
    logic              err_reg, err_next;
    logic [3:0]        stat_reg;
    logic [PC_W-1:0]   imm_sx, imm_zx;

    // Branch immediates always come from the held instruction, widened to PC_W.
    genvar gi;
    generate
        for (gi = 0; gi < PC_W; gi++) begin : g_imm
            if (gi < 16) begin : g_lo
                assign imm_sx[gi] = ir_reg[gi];
                assign imm_zx[gi] = ir_reg[gi];
            end else begin : g_hi
                assign imm_sx[gi] = ir_reg[15];
                assign imm_zx[gi] = 1'b0;
            end
        end
    endgenerate

    always_comb begin
        pc_next = pc_reg;
        if (pc_rst) begin
            pc_next = '0;
        end else if (pc_write) begin
            if (!pc_sel)
                pc_next = pc_reg + {{(PC_W-1){1'b0}}, 1'b1};
            else if (br_sel)
                pc_next = imm_zx;
            else
                pc_next = pc_reg + imm_sx;
        end
    end

    // Only one fetch may be outstanding; a second request is flagged, not queued.
    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        ir_next    = ir_reg;
        err_next   = err_reg;
        case (state_reg)
            IDLE: begin
                if (ir_load) begin
                    state_next = WAIT;
                    addr_next  = pc_reg;
                end
            end
            WAIT: begin
                if (ir_load)
                    err_next = 1'b1;
                if (imem_ready) begin
                    state_next = IDLE;
                    ir_next    = imem_rdata;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_f) begin
            state_reg <= IDLE;
            pc_reg    <= '0;
            addr_reg  <= '0;
            ir_reg    <= '0;
            err_reg   <= 1'b0;
            stat_reg  <= 4'h0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            addr_reg  <= addr_next;
            ir_reg    <= ir_next;
            err_reg   <= err_next;
            if (stat_en)
                stat_reg <= stat_in;
        end
    end

    assign imem_addr = addr_reg;
    assign imem_req  = (state_reg == WAIT);
    assign busy      = (state_reg == WAIT);
    assign pc_out    = pc_reg;
    assign ir        = ir_reg;
    assign opcode    = ir_reg[31:28];
    assign mm        = ir_reg[27:24];
    assign imm       = ir_reg[15:0];
    assign stat      = stat_reg;
    assign fetch_err = err_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a scoreboard queue holds the instruction word
// each fetch must deliver; the memory responder returns words from a fixed image.
module tb_fetch_unit;
    localparam int PC_W = 16;
    localparam int IR_W = 32;

    logic            clk = 1'b0;
    logic            rst_f, pc_rst, pc_write, pc_sel, br_sel, ir_load;
    logic [3:0]      stat_in;
    logic            stat_en;
    logic [PC_W-1:0] imem_addr;
    logic            imem_req;
    logic [IR_W-1:0] imem_rdata;
    logic            imem_ready;
    logic [PC_W-1:0] pc_out;
    logic [IR_W-1:0] ir;
    logic [3:0]      opcode, mm, stat;
    logic [15:0]     imm;
    logic            busy, fetch_err;

    int checks = 0;
    int passed = 0;
    logic [31:0] exp_q[$];

    fetch_unit #(.PC_W(PC_W), .IR_W(IR_W)) dut (
        .clk(clk), .rst_f(rst_f), .pc_rst(pc_rst), .pc_write(pc_write),
        .pc_sel(pc_sel), .br_sel(br_sel), .ir_load(ir_load),
        .stat_in(stat_in), .stat_en(stat_en),
        .imem_addr(imem_addr), .imem_req(imem_req),
        .imem_rdata(imem_rdata), .imem_ready(imem_ready),
        .pc_out(pc_out), .ir(ir), .opcode(opcode), .mm(mm), .imm(imm),
        .stat(stat), .busy(busy), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] memf(input logic [15:0] a);
        case (a)
            16'h0000: memf = 32'h1A00_0005;
            16'h0005: memf = 32'h2000_0010;
            16'h0010: memf = 32'h3000_FFFE;
            16'h000E: memf = 32'h4000_0040;
            16'h0040: memf = 32'h5000_FFFF;
            16'h0001: memf = 32'h6000_0020;
            default:  memf = {16'hBEEF, a};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Advance one cycle, sample 1 time unit after the edge, then refresh the responder.
    task automatic step();
        @(posedge clk);
        #1;
        imem_rdata = imem_req ? memf(imem_addr) : 32'hFFFF_FFFF;
    endtask

    task automatic pop_check(input string tag);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            $error("FAIL %s scoreboard empty, ir=0x%0h", tag, ir);
        end else begin
            e = exp_q.pop_front();
            chk(tag, ir, e);
            $display("fetch %s: ir=0x%08h expected=0x%08h", tag, ir, e);
        end
    endtask

    task automatic fetch_zw(input string tag, input logic [15:0] a);
        logic [31:0] prev;
        prev = ir;
        exp_q.push_back(memf(a));
        ir_load    = 1'b1;
        imem_ready = 1'b1;
        step();
        ir_load = 1'b0;
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_req"}, imem_req, 1);
        chk({tag, "_addr"}, imem_addr, a);
        chk({tag, "_ir_early"}, ir, prev);
        step();
        imem_ready = 1'b0;
        pop_check(tag);
        chk({tag, "_busy_done"}, busy, 0);
        chk({tag, "_req_done"}, imem_req, 0);
    endtask

    task automatic branch(input logic sel, input logic br);
        pc_sel   = sel;
        br_sel   = br;
        pc_write = 1'b1;
        step();
        pc_write = 1'b0;
        pc_sel   = 1'b0;
        br_sel   = 1'b0;
    endtask

    initial begin
        rst_f = 1'b1; pc_rst = 1'b0; pc_write = 1'b0; pc_sel = 1'b0; br_sel = 1'b0;
        ir_load = 1'b0; stat_in = 4'h0; stat_en = 1'b0;
        imem_ready = 1'b0; imem_rdata = 32'hFFFF_FFFF;
        step();
        step();
        chk("rst_pc", pc_out, 0);
        chk("rst_ir", ir, 0);
        chk("rst_stat", stat, 0);
        chk("rst_err", fetch_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_req", imem_req, 0);
        chk("rst_addr", imem_addr, 0);

        // Reset dominates every other input while held
        ir_load = 1'b1; pc_write = 1'b1; stat_en = 1'b1; stat_in = 4'hF; imem_ready = 1'b1;
        step();
        chk("rsthold_pc", pc_out, 0);
        chk("rsthold_stat", stat, 0);
        chk("rsthold_busy", busy, 0);
        step();
        chk("rsthold_req", imem_req, 0);
        chk("rsthold_ir", ir, 0);
        rst_f = 1'b0; ir_load = 1'b0; pc_write = 1'b0; stat_en = 1'b0; stat_in = 4'h0;
        step();
        chk("idle_ready_ir", ir, 0);

        // Zero-wait fetch from address 0 and field decode
        fetch_zw("f0", 16'h0000);
        chk("f0_opcode", opcode, 4'h1);
        chk("f0_mm", mm, 4'hA);
        chk("f0_imm", imm, 16'h0005);

        // Branch chain using imm held in ir
        branch(1'b1, 1'b1);
        chk("abs_to_5", pc_out, 16'h0005);
        fetch_zw("f5", 16'h0005);
        branch(1'b1, 1'b1);
        chk("abs_to_10", pc_out, 16'h0010);
        fetch_zw("f10", 16'h0010);
        chk("f10_imm", imm, 16'hFFFE);
        branch(1'b1, 1'b0);
        chk("rel_to_0E", pc_out, 16'h000E);
        fetch_zw("fE", 16'h000E);
        branch(1'b1, 1'b1);
        chk("abs_to_40", pc_out, 16'h0040);
        fetch_zw("f40", 16'h0040);
        branch(1'b1, 1'b1);
        chk("abs_to_FFFF", pc_out, 16'hFFFF);
        branch(1'b0, 1'b0);
        chk("seq_wrap", pc_out, 16'h0000);
        branch(1'b0, 1'b0);
        chk("seq_inc", pc_out, 16'h0001);

        // Delayed response, concurrent PC update, overlap error, pc_rst mid-fetch
        exp_q.push_back(memf(16'h0001));
        ir_load = 1'b1; pc_write = 1'b1; pc_sel = 1'b0; imem_ready = 1'b0;
        step();
        ir_load = 1'b0; pc_write = 1'b0;
        chk("dly1_busy", busy, 1);
        chk("dly1_req", imem_req, 1);
        chk("dly1_addr", imem_addr, 16'h0001);
        chk("dly1_pc", pc_out, 16'h0002);
        chk("dly1_err", fetch_err, 0);
        ir_load = 1'b1;
        step();
        ir_load = 1'b0;
        chk("dly2_busy", busy, 1);
        chk("dly2_addr", imem_addr, 16'h0001);
        chk("dly2_err", fetch_err, 1);
        pc_rst = 1'b1;
        step();
        pc_rst = 1'b0;
        chk("dly3_busy", busy, 1);
        chk("dly3_req", imem_req, 1);
        chk("dly3_pc", pc_out, 16'h0000);
        step();
        chk("dly4_busy", busy, 1);
        chk("dly4_req", imem_req, 1);
        chk("dly4_addr", imem_addr, 16'h0001);
        chk("dly4_ir", ir, 32'h5000_FFFF);
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        pop_check("f1_delayed");
        chk("dly_done_busy", busy, 0);
        chk("dly_done_req", imem_req, 0);
        chk("dly_queue_empty", exp_q.size(), 0);
        step();
        chk("dly_after_ir", ir, 32'h6000_0020);
        chk("err_sticky", fetch_err, 1);

        // Ready while idle is ignored
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        chk("idle_ready_hold", ir, 32'h6000_0020);

        branch(1'b1, 1'b1);
        chk("abs_to_20", pc_out, 16'h0020);
        pc_rst = 1'b1; pc_write = 1'b1; pc_sel = 1'b0;
        step();
        pc_rst = 1'b0; pc_write = 1'b0;
        chk("pc_rst_prio", pc_out, 16'h0000);

        stat_en = 1'b1; stat_in = 4'h9;
        step();
        stat_en = 1'b0; stat_in = 4'h6;
        chk("stat_load", stat, 4'h9);
        step();
        chk("stat_hold", stat, 4'h9);
        chk("err_sticky2", fetch_err, 1);

        // Reset mid-fetch abandons the request
        exp_q.push_back(memf(16'h0000));
        ir_load = 1'b1;
        step();
        ir_load = 1'b0;
        chk("abort_busy_pre", busy, 1);
        rst_f = 1'b1;
        step();
        rst_f = 1'b0;
        void'(exp_q.pop_front());
        $display("fetch abort: abandoned by reset");
        chk("abort_busy", busy, 0);
        chk("abort_req", imem_req, 0);
        chk("abort_ir", ir, 0);
        chk("abort_err", fetch_err, 0);
        chk("abort_stat", stat, 0);
        chk("abort_addr", imem_addr, 0);
        imem_ready = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_ready = 1'b0;
        chk("abort_late_ir", ir, 0);
        chk("abort_late_busy", busy, 0);
        chk("abort_late_req", imem_req, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
